// File: rtl/countdown_round_ctrl_if.sv
// Control and display bus of the countdown round controller.
// The master side drives the round commands and reads back the count,
// state and multiplexed display lines.
interface countdown_round_ctrl_if;
    logic       start;
    logic       pause;
    logic       abort;
    logic [6:0] load_val;
    logic [6:0] count;
    logic [1:0] state;
    logic       done;
    logic [3:0] digit;
    logic [3:0] an;

    modport master (
        output start, pause, abort, load_val,
        input  count, state, done, digit, an
    );

    modport slave (
        input  start, pause, abort, load_val,
        output count, state, done, digit, an
    );
endinterface

// File: rtl/countdown_round_ctrl.sv
// Countdown round controller: runs a 0..99 countdown stepped by a clock
// prescaler, supports pause/resume and abort, and drives a two-digit
// multiplexed 7-segment display (BCD digit plus active-low anodes).
module countdown_round_ctrl #(
    parameter int TICK_DIV = 50000000,
    parameter int SCAN_DIV = 131072
) (
    input  logic                  clk,
    input  logic                  reset,
    countdown_round_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_RUN     = 2'b01,
        S_PAUSE   = 2'b10,
        S_EXPIRED = 2'b11
    } state_t;

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);

    // Clamp a requested start value to the two-digit display range.
    function automatic logic [6:0] sat99(input logic [6:0] v);
        return (v > 7'd99) ? 7'd99 : v;
    endfunction

    function automatic logic [3:0] bcd_ones(input logic [6:0] v);
        return 4'(v % 7'd10);
    endfunction

    function automatic logic [3:0] bcd_tens(input logic [6:0] v);
        return 4'(v / 7'd10);
    endfunction

    state_t        state_q, state_d;
    logic [6:0]    count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          done_q, done_d;
    logic [SW-1:0] scan_q;
    logic          slot_q;
    logic [3:0]    digit_q;
    logic [3:0]    an_q;
    logic          tick;

    assign tick = (presc_q == PRESC_MAX);

    // Round state, count and prescaler registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= 7'd0;
            presc_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            presc_q <= presc_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: abort beats start beats pause beats tick.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        if (bus.abort) begin
            state_d = S_IDLE;
            count_d = 7'd0;
            presc_d = '0;
        end else if (bus.start && (state_q == S_IDLE || state_q == S_EXPIRED)) begin
            state_d = S_RUN;
            count_d = sat99(bus.load_val);
            presc_d = '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (bus.pause) begin
                        // Prescaler is frozen, so a coinciding tick is deferred, not lost.
                        state_d = S_PAUSE;
                    end else if (count_q == 7'd0) begin
                        // Round started at zero expires immediately.
                        state_d = S_EXPIRED;
                        done_d  = 1'b1;
                    end else if (tick) begin
                        presc_d = '0;
                        count_d = count_q - 7'd1;
                        if (count_q == 7'd1) begin
                            state_d = S_EXPIRED;
                            done_d  = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (bus.pause) state_d = S_RUN;
                end
                default: ;
            endcase
        end
    end

    // Free-running digit scan; the slot flips each time the scan counter wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_q <= '0;
            slot_q <= 1'b0;
        end else if (scan_q == SCAN_MAX) begin
            scan_q <= '0;
            slot_q <= ~slot_q;
        end else begin
            scan_q <= scan_q + 1'b1;
        end
    end

    // Registered display drive: ones in slot 0, tens (blanked when zero) in slot 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            digit_q <= 4'd0;
            an_q    <= 4'b1111;
        end else if (!slot_q) begin
            digit_q <= bcd_ones(count_q);
            an_q    <= 4'b1110;
        end else begin
            digit_q <= bcd_tens(count_q);
            an_q    <= (bcd_tens(count_q) != 4'd0) ? 4'b1101 : 4'b1111;
        end
    end

    assign bus.count = count_q;
    assign bus.state = state_q;
    assign bus.done  = done_q;
    assign bus.digit = digit_q;
    assign bus.an    = an_q;

endmodule
